// File: rtl/comp.sv
// rtl/comp.sv - OLED drive compensation: VDATA = VDD - VTH - sqrt(2*IOLED/K), optional COMP_SAT_EN clamps negative results to zero
module comp (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  IOLED,
    input  logic [3:0]  K,
    input  logic [15:0] VDD,
    input  logic [15:0] VTH,
    output logic [15:0] VDATA
);

    logic [25:0]        quotient;
    logic [3:0]         divisor;
    logic [12:0]        root;
    logic [15:0]        rem;
    logic [15:0]        trial;
    logic signed [17:0] diff;
    logic [15:0]        vdata_next;

    // The divisor is forced to 1 when K is zero; that result is discarded below.
    assign divisor  = (K == 4'd0) ? 4'd1 : K;
    assign quotient = {IOLED, 17'd0} / {22'd0, divisor};

    // Digit-by-digit integer square root: two radicand bits per step, 13 steps.
    always_comb begin
        rem   = 16'd0;
        root  = 13'd0;
        trial = 16'd0;
        for (int i = 12; i >= 0; i--) begin
            rem   = {rem[13:0], quotient[2*i +: 2]};
            trial = {1'b0, root, 2'b01};
            if (rem >= trial) begin
                rem  = rem - trial;
                root = {root[11:0], 1'b1};
            end else begin
                root = {root[11:0], 1'b0};
            end
        end
    end

    // Full-precision signed difference; 18 bits cover every input combination.
    assign diff = $signed({2'b00, VDD}) - $signed({2'b00, VTH}) - $signed({5'b00000, root});

    // Map the signed difference onto the 16-bit output range.
    always_comb begin
        vdata_next = diff[15:0];
        if (K == 4'd0) begin
            vdata_next = 16'h0000;
        end else if (!diff[17] && diff[16]) begin
            vdata_next = 16'hFFFF;
`ifdef COMP_SAT_EN
        end else if (diff[17]) begin
            vdata_next = 16'h0000;
`else
        end else if (diff[17]) begin
            vdata_next = diff[15:0];
`endif
        end
    end

    // Output register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            VDATA <= 16'h0000;
        end else begin
            VDATA <= vdata_next;
        end
    end

endmodule

// File: tb/tb_comp.sv
// tb/tb_comp.sv - scoreboard testbench for comp
module tb_comp;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  IOLED;
    logic [3:0]  K;
    logic [15:0] VDD;
    logic [15:0] VTH;
    logic [15:0] VDATA;

    int checks   = 0;
    int failures = 0;
    logic [15:0] expq[$];

    comp dut (
        .clk   (clk),
        .reset (reset),
        .IOLED (IOLED),
        .K     (K),
        .VDD   (VDD),
        .VTH   (VTH),
        .VDATA (VDATA)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic r, input int io, input int k,
                                          input int vdd, input int vth);
        longint q;
        longint s;
        longint t;
        int d;
        if (!r || k == 0) return 16'h0000;
        q = (longint'(2 * io) << 16) / k;
        s = 0;
        for (int b = 12; b >= 0; b--) begin
            t = s | (longint'(1) << b);
            if (t * t <= q) s = t;
        end
        d = vdd - vth - int'(s);
`ifdef COMP_SAT_EN
        if (d < 0) return 16'h0000;
`endif
        return d[15:0];
    endfunction

    // Drive one cycle of inputs between edges, push the expected value, compare after the edge.
    task automatic step(input string tag, input logic r, input int io, input int k,
                        input int vdd, input int vth, input int exp_const);
        logic [15:0] e;
        @(negedge clk);
        reset = r;
        IOLED = io[8:0];
        K     = k[3:0];
        VDD   = vdd[15:0];
        VTH   = vth[15:0];
        e = (exp_const < 0) ? model(r, io, k, vdd, vth) : exp_const[15:0];
        expq.push_back(e);
        @(posedge clk);
        #1;
        check_eq(tag, VDATA, expq.pop_front());
    endtask

    initial begin
        reset = 1'b0; IOLED = '0; K = '0; VDD = '0; VTH = '0;
        step("reset_state", 1'b0, 40, 10, 'h0800, 'h0100, 0);
        step("reset_hold", 1'b0, 100, 3, 'h0900, 'h0010, 0);
        step("basic_042c", 1'b1, 40, 10, 'h0800, 'h0100, 'h042C);
        step("vth_change_052c", 1'b1, 40, 10, 'h0800, 'h0000, 'h052C);
        step("ioled_zero", 1'b1, 0, 10, 'h0800, 'h0200, 'h0600);
`ifdef COMP_SAT_EN
        step("negative_sat", 1'b1, 511, 1, 'h0800, 'h0100, 'h0000);
`else
        step("negative_wrap", 1'b1, 511, 1, 'h0800, 'h0100, 'hE709);
`endif
        step("k_zero_a", 1'b1, 40, 0, 'h0800, 'h0100, 0);
        step("k_zero_b", 1'b1, 511, 0, 'hFFFF, 'h0000, 0);
        step("max_vdd", 1'b1, 0, 15, 'hFFFF, 'h0000, 'hFFFF);
        step("pre_reset", 1'b1, 40, 10, 'h0800, 'h0100, 'h042C);
        step("mid_reset", 1'b0, 40, 10, 'h0800, 'h0100, 0);
        step("post_reset", 1'b1, 40, 10, 'h0800, 'h0100, 'h042C);
        step("k15_model", 1'b1, 511, 15, 'h0800, 'h0100, -1);
        for (int n = 0; n < 60; n++) begin
            step("random", ($urandom_range(0, 9) != 0), int'($urandom_range(0, 511)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)),
                 int'($urandom_range(0, 65535)), -1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
